// File: rtl/pipeline_control_if.sv
// Control-path bundle between the fetch/decode datapath and the pipelined control block.
// The control block is the master: it drives decode, hazard and per-stage control outputs.
interface pipeline_control_if #(
  parameter int OP_WIDTH = 7,
  parameter int REG_AW   = 5
);
  logic [OP_WIDTH-1:0] op;
  logic [2:0]          funct3;
  logic                funct7b5;
  logic [REG_AW-1:0]   Rs1D;
  logic [REG_AW-1:0]   Rs2D;
  logic [REG_AW-1:0]   RdD;
  logic                CondE;
  logic                MemBusyM;

  logic [2:0]          ImmSrcD;
  logic                IllegalD;
  logic                ALUSrcE;
  logic [2:0]          ALUControlE;
  logic [REG_AW-1:0]   Rs1E;
  logic [REG_AW-1:0]   Rs2E;
  logic [1:0]          ForwardAE;
  logic [1:0]          ForwardBE;
  logic                PCSrcE;
  logic                MemWriteM;
  logic [1:0]          ResultSrcW;
  logic                RegWriteW;
  logic [REG_AW-1:0]   RdW;
  logic                StallF;
  logic                StallD;
  logic                FlushD;

  modport master (
    input  op, funct3, funct7b5, Rs1D, Rs2D, RdD, CondE, MemBusyM,
    output ImmSrcD, IllegalD, ALUSrcE, ALUControlE, Rs1E, Rs2E,
           ForwardAE, ForwardBE, PCSrcE, MemWriteM, ResultSrcW,
           RegWriteW, RdW, StallF, StallD, FlushD
  );

  modport slave (
    output op, funct3, funct7b5, Rs1D, Rs2D, RdD, CondE, MemBusyM,
    input  ImmSrcD, IllegalD, ALUSrcE, ALUControlE, Rs1E, Rs2E,
           ForwardAE, ForwardBE, PCSrcE, MemWriteM, ResultSrcW,
           RegWriteW, RdW, StallF, StallD, FlushD
  );
endinterface

// File: rtl/pipeline_control.sv
// RV32I 5-stage control: D-stage decode, registered E/M/W control bundle, hazard/forward/redirect.
// Latency: decode combinational; E outputs +1 cycle, MemWriteM +2, W outputs +3.
// Backpressure: MemBusyM freezes every stage register and holds fetch/decode.
module pipeline_control #(
  parameter int OP_WIDTH   = 7,
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1
) (
  input logic                clk,
  input logic                rst,
  pipeline_control_if.master bus
);
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_IALU  = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BRNCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(7'b0110111);

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [2:0] alucontrol;
    logic       alusrc;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic [REG_AW-1:0] rd;
  } wb_t;

  ctrl_t      ctl_d;
  logic [2:0] imm_d;
  logic       ill_d;
  ex_t        ex_d, ex_q;
  mem_t       mem_d, mem_q;
  wb_t        wb_d, wb_q;
  logic       hazard, pcsrc, stall, flushd, flushe;

  function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input mem_t m, input wb_t w);
    if (FORWARD_EN == 0)                             return 2'b00;
    if (m.regwrite && (m.rd != '0) && (m.rd == rs)) return 2'b10;
    if (w.regwrite && (w.rd != '0) && (w.rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    ctl_d = '0;
    imm_d = 3'b000;
    ill_d = 1'b0;
    case (bus.op)
      OP_LOAD:  begin ctl_d.regwrite = 1'b1; ctl_d.alusrc = 1'b1; ctl_d.resultsrc = 2'b01; end
      OP_STORE: begin ctl_d.memwrite = 1'b1; ctl_d.alusrc = 1'b1; imm_d = 3'b001; end
      OP_RTYPE: begin ctl_d.regwrite = 1'b1; ctl_d.alucontrol = alu_map(bus.funct3, bus.funct7b5); end
      OP_IALU:  begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = 1'b1;
        ctl_d.alucontrol = alu_map(bus.funct3, 1'b0);
      end
      OP_BRNCH: begin ctl_d.branch = 1'b1; ctl_d.alucontrol = 3'b001; imm_d = 3'b010; end
      OP_JAL:   begin ctl_d.jump = 1'b1; ctl_d.regwrite = 1'b1; ctl_d.resultsrc = 2'b10; imm_d = 3'b011; end
      OP_LUI:   begin ctl_d.regwrite = 1'b1; ctl_d.resultsrc = 2'b11; imm_d = 3'b100; end
      default:  ill_d = 1'b1;
    endcase
  end

  // Without bypassing, any live writer in E or M blocks a reader in D; W is covered by the
  // falling-edge register-file write.
  always_comb begin
    logic match_e, match_m;
    match_e = (ex_q.rd != '0) && ((ex_q.rd == bus.Rs1D) || (ex_q.rd == bus.Rs2D));
    match_m = (mem_q.rd != '0) && ((mem_q.rd == bus.Rs1D) || (mem_q.rd == bus.Rs2D));
    if (FORWARD_EN != 0)
      hazard = (ex_q.ctl.resultsrc == 2'b01) && match_e;
    else
      hazard = (ex_q.ctl.regwrite && match_e) || (mem_q.regwrite && match_m);
  end

  assign pcsrc = ((ex_q.ctl.branch & bus.CondE) | ex_q.ctl.jump) & ~bus.MemBusyM;

  always_comb begin
    stall  = 1'b0;
    flushd = 1'b0;
    flushe = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (bus.MemBusyM) begin
      stall = 1'b1;
    end else if (pcsrc) begin
      flushd = 1'b1;
      flushe = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      flushe = 1'b1;
    end
  end

  always_comb begin
    ex_d  = '{ctl: ctl_d, rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD};
    mem_d = '{regwrite: ex_q.ctl.regwrite, resultsrc: ex_q.ctl.resultsrc,
              memwrite: ex_q.ctl.memwrite, rd: ex_q.rd};
    wb_d  = '{regwrite: mem_q.regwrite, resultsrc: mem_q.resultsrc, rd: mem_q.rd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.MemBusyM) begin
      ex_q  <= flushe ? '0 : ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.ImmSrcD     = imm_d;
  assign bus.IllegalD    = ill_d;
  assign bus.ALUSrcE     = ex_q.ctl.alusrc;
  assign bus.ALUControlE = ex_q.ctl.alucontrol;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.ForwardAE   = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign bus.ForwardBE   = fwd_sel(ex_q.rs2, mem_q, wb_q);
  assign bus.PCSrcE      = pcsrc;
  assign bus.MemWriteM   = mem_q.memwrite;
  assign bus.ResultSrcW  = wb_q.resultsrc;
  assign bus.RegWriteW   = wb_q.regwrite;
  assign bus.RdW         = wb_q.rd;
  assign bus.StallF      = stall;
  assign bus.StallD      = stall;
  assign bus.FlushD      = flushd;
endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: one DUT with bypassing (dut_a), one without (dut_b), shared stimulus.
// An instruction-level model tracks which instruction occupies E/M/W in each DUT.
module tb_pipeline_control;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         IALU = 7'b0010011, BRNCH = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ins_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rsrc;
    logic       mw;
    logic       jmp;
    logic       br;
    logic [2:0] alu;
    logic       asrc;
    logic [2:0] imm;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] d_op;
  logic [2:0] d_f3;
  logic       d_f7;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       cond, busy;
  int         checks = 0;
  int         failures = 0;
  ins_t       st [2][3];   // [0]=no-forward DUT, [1]=forward DUT; stages E, M, W

  pipeline_control_if #(.OP_WIDTH(7), .REG_AW(5)) ifa ();
  pipeline_control_if #(.OP_WIDTH(7), .REG_AW(5)) ifb ();

  assign {ifa.op, ifa.funct3, ifa.funct7b5, ifa.Rs1D, ifa.Rs2D, ifa.RdD, ifa.CondE, ifa.MemBusyM} =
         {d_op, d_f3, d_f7, d_rs1, d_rs2, d_rd, cond, busy};
  assign {ifb.op, ifb.funct3, ifb.funct7b5, ifb.Rs1D, ifb.Rs2D, ifb.RdD, ifb.CondE, ifb.MemBusyM} =
         {d_op, d_f3, d_f7, d_rs1, d_rs2, d_rd, cond, busy};

  pipeline_control #(.OP_WIDTH(7), .REG_AW(5), .FORWARD_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipeline_control #(.OP_WIDTH(7), .REG_AW(5), .FORWARD_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  function automatic ctl_t dec(input ins_t i);
    ctl_t       c;
    logic [2:0] amap [8];
    amap = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    c = '0;
    case (i.op)
      LOAD:    begin c.rw = 1'b1; c.rsrc = 2'd1; c.asrc = 1'b1; end
      STORE:   begin c.mw = 1'b1; c.asrc = 1'b1; c.imm = 3'd1; end
      RTYPE:   begin c.rw = 1'b1; c.alu = (i.f3 == 3'd0 && i.f7) ? 3'd1 : amap[i.f3]; end
      IALU:    begin c.rw = 1'b1; c.asrc = 1'b1; c.alu = amap[i.f3]; end
      BRNCH:   begin c.br = 1'b1; c.alu = 3'd1; c.imm = 3'd2; end
      JAL:     begin c.jmp = 1'b1; c.rw = 1'b1; c.rsrc = 2'd2; c.imm = 3'd3; end
      LUI:     begin c.rw = 1'b1; c.rsrc = 2'd3; c.imm = 3'd4; end
      default: c.ill = 1'b1;
    endcase
    return c;
  endfunction

  function automatic ins_t dnow();
    return {d_op, d_f3, d_f7, d_rs1, d_rs2, d_rd};
  endfunction

  function automatic logic uses(input ins_t w, input logic [4:0] a, input logic [4:0] b);
    return (w.rd != 5'd0) && ((w.rd == a) || (w.rd == b));
  endfunction

  function automatic logic exp_pc(input int k);
    ctl_t e = dec(st[k][0]);
    return !rst && !busy && ((e.br && cond) || e.jmp);
  endfunction

  function automatic logic exp_haz(input int k);
    if (k == 1)
      return (dec(st[k][0]).rsrc == 2'd1) && uses(st[k][0], d_rs1, d_rs2);
    return (dec(st[k][0]).rw && uses(st[k][0], d_rs1, d_rs2)) ||
           (dec(st[k][1]).rw && uses(st[k][1], d_rs1, d_rs2));
  endfunction

  function automatic logic exp_stall(input int k);
    return !rst && (busy || (!exp_pc(k) && exp_haz(k)));
  endfunction

  function automatic logic [1:0] exp_fwd(input int k, input logic [4:0] rs);
    if (k == 0) return 2'd0;
    if (dec(st[k][1]).rw && st[k][1].rd != 5'd0 && st[k][1].rd == rs) return 2'd2;
    if (dec(st[k][2]).rw && st[k][2].rd != 5'd0 && st[k][2].rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) for (int s = 0; s < 3; s++) st[k][s] = '0;
    end else if (!busy) begin
      for (int k = 0; k < 2; k++) begin
        logic bub;
        bub = exp_pc(k) || exp_haz(k);
        st[k][2] = st[k][1];
        st[k][1] = st[k][0];
        st[k][0] = bub ? '0 : dnow();
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [2:0] imm, input logic ill, input logic asrc,
                     input logic [2:0] alu, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [1:0] fa, input logic [1:0] fb, input logic pcs, input logic mw,
                     input logic [1:0] rsw, input logic rww, input logic [4:0] rdw,
                     input logic sf, input logic sd, input logic fd);
    ctl_t cd, ce, cm, cw;
    cd = dec(dnow());
    ce = dec(st[k][0]);
    cm = dec(st[k][1]);
    cw = dec(st[k][2]);
    chk("ImmSrcD", k, 8'(imm), 8'(cd.imm));
    chk("IllegalD", k, 8'(ill), 8'(cd.ill));
    chk("ALUSrcE", k, 8'(asrc), 8'(ce.asrc));
    chk("ALUControlE", k, 8'(alu), 8'(ce.alu));
    chk("Rs1E", k, 8'(r1), 8'(st[k][0].rs1));
    chk("Rs2E", k, 8'(r2), 8'(st[k][0].rs2));
    chk("ForwardAE", k, 8'(fa), 8'(exp_fwd(k, st[k][0].rs1)));
    chk("ForwardBE", k, 8'(fb), 8'(exp_fwd(k, st[k][0].rs2)));
    chk("PCSrcE", k, 8'(pcs), 8'(exp_pc(k)));
    chk("MemWriteM", k, 8'(mw), 8'(cm.mw));
    chk("ResultSrcW", k, 8'(rsw), 8'(cw.rsrc));
    chk("RegWriteW", k, 8'(rww), 8'(cw.rw));
    chk("RdW", k, 8'(rdw), 8'(st[k][2].rd));
    chk("StallF", k, 8'(sf), 8'(exp_stall(k)));
    chk("StallD", k, 8'(sd), 8'(exp_stall(k)));
    chk("FlushD", k, 8'(fd), 8'(exp_pc(k)));
  endtask

  always @(negedge clk) begin
    cmp(0, ifb.ImmSrcD, ifb.IllegalD, ifb.ALUSrcE, ifb.ALUControlE, ifb.Rs1E, ifb.Rs2E,
        ifb.ForwardAE, ifb.ForwardBE, ifb.PCSrcE, ifb.MemWriteM, ifb.ResultSrcW,
        ifb.RegWriteW, ifb.RdW, ifb.StallF, ifb.StallD, ifb.FlushD);
    cmp(1, ifa.ImmSrcD, ifa.IllegalD, ifa.ALUSrcE, ifa.ALUControlE, ifa.Rs1E, ifa.Rs2E,
        ifa.ForwardAE, ifa.ForwardBE, ifa.PCSrcE, ifa.MemWriteM, ifa.ResultSrcW,
        ifa.RegWriteW, ifa.RdW, ifa.StallF, ifa.StallD, ifa.FlushD);
  end

  task automatic set_i(input logic [6:0] o, input logic [2:0] f, input logic f7,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    d_op = o; d_f3 = f; d_f7 = f7; d_rs1 = a; d_rs2 = b; d_rd = d;
  endtask

  task automatic nop();
    set_i(IALU, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; cond = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWriteW", 1, 8'(ifa.RegWriteW), 8'd0);
    chk("rst_RdW", 1, 8'(ifa.RdW), 8'd0);
    chk("rst_StallF", 0, 8'(ifb.StallF), 8'd0);
    chk("rst_ALUSrcE", 1, 8'(ifa.ALUSrcE), 8'd0);
    rst = 1'b0;
    drain();

    // add x3,x1,x2 ; sub x4,x3,x1 -> M-stage bypass
    set_i(RTYPE, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    set_i(RTYPE, 3'd0, 1'b1, 5'd3, 5'd1, 5'd4); tick();
    nop(); look();
    chk("fwd_ForwardAE", 1, 8'(ifa.ForwardAE), 8'd2);
    chk("fwd_ALUControlE", 1, 8'(ifa.ALUControlE), 8'd1);
    chk("fwd_StallF", 1, 8'(ifa.StallF), 8'd0);
    drain();

    // lw x5,0(x1) ; add x6,x5,x0 -> one load-use bubble, then W bypass
    set_i(LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd5); look();
    chk("lw_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd0);
    chk("lw_IllegalD", 1, 8'(ifa.IllegalD), 8'd0);
    tick();
    set_i(RTYPE, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6); look();
    chk("lu_StallF", 1, 8'(ifa.StallF), 8'd1);
    chk("lu_StallD", 1, 8'(ifa.StallD), 8'd1);
    tick(); look();
    chk("lu_StallF_after", 1, 8'(ifa.StallF), 8'd0);
    chk("lu_bubble_ALUCtl", 1, 8'(ifa.ALUControlE), 8'd0);
    chk("lu_bubble_ALUSrc", 1, 8'(ifa.ALUSrcE), 8'd0);
    tick(); nop(); look();
    chk("lu_ForwardAE", 1, 8'(ifa.ForwardAE), 8'd1);
    chk("lu_Rs1E", 1, 8'(ifa.Rs1E), 8'd5);
    drain();

    // beq taken, then beq not taken
    set_i(BRNCH, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); look();
    chk("br_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd2);
    tick();
    cond = 1'b1; set_i(RTYPE, 3'd0, 1'b0, 5'd1, 5'd2, 5'd9); look();
    chk("bt_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd1);
    chk("bt_FlushD", 1, 8'(ifa.FlushD), 8'd1);
    chk("bt_StallF", 1, 8'(ifa.StallF), 8'd0);
    tick();
    cond = 1'b0; nop(); look();
    chk("bt_bubble_ALUCtl", 1, 8'(ifa.ALUControlE), 8'd0);
    chk("bt_bubble_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd0);
    set_i(BRNCH, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); tick();
    nop(); look();
    chk("bn_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd0);
    chk("bn_FlushD", 1, 8'(ifa.FlushD), 8'd0);
    chk("bn_ALUControlE", 1, 8'(ifa.ALUControlE), 8'd1);
    tick(); look();
    chk("bn_next_ALUSrcE", 1, 8'(ifa.ALUSrcE), 8'd1);
    drain();

    // no bypass: add x3 ; or x7,x3,x3 -> two stalls
    set_i(RTYPE, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    set_i(RTYPE, 3'd6, 1'b0, 5'd3, 5'd3, 5'd7); look();
    chk("nf_StallF1", 0, 8'(ifb.StallF), 8'd1);
    chk("nf_StallD1", 0, 8'(ifb.StallD), 8'd1);
    chk("nf_FlushD1", 0, 8'(ifb.FlushD), 8'd0);
    chk("nf_ForwardAE1", 0, 8'(ifb.ForwardAE), 8'd0);
    tick(); look();
    chk("nf_StallF2", 0, 8'(ifb.StallF), 8'd1);
    tick(); look();
    chk("nf_StallF3", 0, 8'(ifb.StallF), 8'd0);
    chk("nf_ForwardAE3", 0, 8'(ifb.ForwardAE), 8'd0);
    chk("nf_ForwardBE3", 0, 8'(ifb.ForwardBE), 8'd0);
    tick(); nop(); look();
    chk("nf_or_ALUCtl", 0, 8'(ifb.ALUControlE), 8'd3);
    chk("nf_or_Rs1E", 0, 8'(ifb.Rs1E), 8'd3);
    // one independent instruction in between -> one stall
    set_i(RTYPE, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    set_i(IALU, 3'd0, 1'b0, 5'd1, 5'd0, 5'd8); look();
    chk("nf1_StallF_a", 0, 8'(ifb.StallF), 8'd0);
    tick();
    set_i(RTYPE, 3'd6, 1'b0, 5'd3, 5'd3, 5'd7); look();
    chk("nf1_StallF_b", 0, 8'(ifb.StallF), 8'd1);
    tick(); look();
    chk("nf1_StallF_c", 0, 8'(ifb.StallF), 8'd0);
    drain();

    // memory busy with a taken branch in E
    set_i(BRNCH, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); tick();
    busy = 1'b1; cond = 1'b1; nop(); look();
    chk("mb_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd0);
    chk("mb_StallF", 1, 8'(ifa.StallF), 8'd1);
    chk("mb_StallD", 1, 8'(ifa.StallD), 8'd1);
    chk("mb_FlushD", 1, 8'(ifa.FlushD), 8'd0);
    repeat (2) tick();
    look();
    chk("mb_hold_ALUCtl", 1, 8'(ifa.ALUControlE), 8'd1);
    chk("mb_hold_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd0);
    tick();
    busy = 1'b0; look();
    chk("mb_rel_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd1);
    chk("mb_rel_FlushD", 1, 8'(ifa.FlushD), 8'd1);
    tick();
    cond = 1'b0;
    drain();

    // lui x10 ; jal x1 -> redirect and write-back sources
    set_i(LUI, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10); look();
    chk("lui_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd4);
    tick();
    set_i(JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1); look();
    chk("jal_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd3);
    tick(); nop(); look();
    chk("jal_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd1);
    tick(); look();
    chk("lui_ResultSrcW", 1, 8'(ifa.ResultSrcW), 8'd3);
    chk("lui_RegWriteW", 1, 8'(ifa.RegWriteW), 8'd1);
    chk("lui_RdW", 1, 8'(ifa.RdW), 8'd10);
    tick(); look();
    chk("jal_ResultSrcW", 1, 8'(ifa.ResultSrcW), 8'd2);
    chk("jal_RdW", 1, 8'(ifa.RdW), 8'd1);
    drain();

    // sw in M, lw in W, then asynchronous reset
    set_i(LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd5); tick();
    set_i(STORE, 3'd2, 1'b0, 5'd1, 5'd6, 5'd4); look();
    chk("sw_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd1);
    tick(); nop(); tick(); look();
    chk("pre_MemWriteM", 1, 8'(ifa.MemWriteM), 8'd1);
    chk("pre_RegWriteW", 1, 8'(ifa.RegWriteW), 8'd1);
    chk("pre_RdW", 1, 8'(ifa.RdW), 8'd5);
    rst = 1'b1;
    #1;
    chk("ar_MemWriteM", 1, 8'(ifa.MemWriteM), 8'd0);
    chk("ar_RegWriteW", 1, 8'(ifa.RegWriteW), 8'd0);
    chk("ar_RdW", 1, 8'(ifa.RdW), 8'd0);
    chk("ar_RegWriteW", 0, 8'(ifb.RegWriteW), 8'd0);
    tick();
    rst = 1'b0;
    set_i(7'b1111111, 3'd7, 1'b1, 5'd1, 5'd2, 5'd3); look();
    chk("ill_IllegalD", 1, 8'(ifa.IllegalD), 8'd1);
    chk("ill_ImmSrcD", 1, 8'(ifa.ImmSrcD), 8'd0);
    tick(); nop(); look();
    chk("ill_ALUSrcE", 1, 8'(ifa.ALUSrcE), 8'd0);
    chk("ill_ALUControlE", 1, 8'(ifa.ALUControlE), 8'd0);
    chk("ill_PCSrcE", 1, 8'(ifa.PCSrcE), 8'd0);
    chk("ill_Rs1E", 1, 8'(ifa.Rs1E), 8'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
# pipeline_control

Next-generation pipelined control block for the 5-stage RV32I core: decodes the instruction in Decode and carries the control bundle through the registered E, M and W stages. Also contains the hazard logic that generates stall, flush, forwarding and PC-redirect signals. Sits between the fetch/decode datapath and the ALU, data memory and register-file write-back. Parametrised forwarding mode and a memory-busy freeze add behaviour the previous combinational control unit did not have.

## Interface
- OP_WIDTH, 7: opcode width.
- REG_AW, 5: register address width.
- FORWARD_EN, 1: 1 = bypass network plus load-use stall; 0 = no bypass, stall on every RAW hazard.
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  OP_WIDTH  opcode of the instruction in D.
- funct3  in  3  instruction funct3 in D.
- funct7b5  in  1  instruction bit 30 in D.
- Rs1D, Rs2D, RdD  in  REG_AW each  register fields in D.
- CondE  in  1  branch comparison true (from the E-stage ALU).
- MemBusyM  in  1  data memory not ready; freezes the pipeline.
- ImmSrcD  out  3  immediate type: I=000, S=001, B=010, J=011, U=100.
- IllegalD  out  1  opcode not in the decode list.
- ALUSrcE  out  1  ALU operand B selects the immediate.
- ALUControlE  out  3  ALU operation: add=000, sub=001, and=010, or=011, xor=100, slt=101, sll=110, srl=111.
- Rs1E, Rs2E  out  REG_AW  register fields in E.
- ForwardAE, ForwardBE  out  2  operand source: 00 register file, 01 W result, 10 M ALU result.
- PCSrcE  out  1  redirect PC to the branch/jump target.
- MemWriteM  out  1  store enable.
- ResultSrcW  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4, 11 U-immediate.
- RegWriteW  out  1  register write enable.
- RdW  out  REG_AW  write-back destination register.
- StallF, StallD, FlushD  out  1 each  fetch/decode register controls.

## Operation
- Decode (combinational, D stage):
  - load 0000011: RegWrite, ALUSrc, ResultSrc=01, Imm I, ALU add.
  - store 0100011: MemWrite, ALUSrc, Imm S, ALU add.
  - R-type 0110011: RegWrite. funct3 000 gives sub if funct7b5 else add; 100 xor; 110 or; 111 and; 010 slt; 001 sll; 101 srl.
  - I-ALU 0010011: RegWrite, ALUSrc, Imm I. Same funct3 map, except 000 is always add.
  - branch 1100011: Branch, Imm B, ALU sub.
  - jal 1101111: Jump, RegWrite, ResultSrc=10, Imm J.
  - lui 0110111: RegWrite, ResultSrc=11, Imm U.
  - any other opcode: every control bit 0 and IllegalD=1.
- Registers: D→E holds the bundle plus Rs1, Rs2 and Rd; E→M and M→W hold the subset still needed downstream. A bubble is all-zero control with Rd=0.
- PCSrcE = (BranchE & CondE | JumpE) & ~MemBusyM.
- Forwarding (FORWARD_EN=1):
  - ForwardAE=10 if RegWriteM, RdM≠0 and RdM=Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW, RdW≠0 and RdW=Rs1E.
  - Otherwise ForwardAE=00. ForwardBE is the same with Rs2E.
- Load-use (FORWARD_EN=1): ResultSrcE=01, RdE≠0 and RdE∈{Rs1D, Rs2D} gives StallF=StallD=1 and FlushE.
- FORWARD_EN=0:
  - Forward outputs are held at 00.
  - Stall (StallF, StallD, FlushE) while a nonzero RdE with RegWriteE, or a nonzero RdM with RegWriteM, matches Rs1D or Rs2D.
  - The register file writes on the falling edge, so a W-stage match needs no stall.
  - Matches are compared conservatively; the opcode does not mask them.
- Priority, highest first:
  - rst: all registers cleared.
  - MemBusyM: every stage register holds; StallF=StallD=1; FlushD=0; no flush applied.
  - PCSrcE: FlushD=1, E loads a bubble, StallF=StallD=0.
  - Hazard stall.

## Timing
- Reset: all pipeline registers cleared. Every E/M/W output is 0, ForwardAE/BE=00, PCSrcE=0, StallF/StallD/FlushD=0, RdW=0.
- D-stage outputs (ImmSrcD, IllegalD) are combinational, with zero latency.
- Latency: a decoded bundle appears on E outputs 1 cycle after leaving D, MemWriteM after 2 cycles, and W outputs after 3 cycles.
- A flush or bubble takes effect at the next rising edge.
- Load-use stall lasts exactly 1 cycle.
- Without forwarding, a dependent instruction stalls 2 cycles behind its producer, or 1 cycle if one independent instruction separates them.
- Reset asserted mid-stream discards all in-flight control immediately; no write enable may be high while rst=1.

## Test plan
- add x3,x1,x2 followed by sub x4,x3,x1 (FORWARD_EN=1) -> in sub's E cycle ForwardAE=10, ALUControlE=001, no stall.
- lw x5,0(x1) followed by add x6,x5,x0 -> StallF=StallD=1 for 1 cycle and E bubble (ALUControlE=000, RegWrite 0), then ForwardAE=01.
- beq with CondE=1 -> PCSrcE=1 and FlushD=1 that cycle; next cycle all E control is 0. With CondE=0, no flush.
- FORWARD_EN=0, add x3,… followed immediately by or x7,x3,x3 -> 2 stall cycles, ForwardAE/BE stay 00, and or reaches E on the third cycle.
- MemBusyM=1 for 3 cycles with a taken branch in E -> PCSrcE=0 and all outputs hold; PCSrcE=1 on the first cycle after release.
- rst pulse while sw is in M and lw in W -> MemWriteM=0, RegWriteW=0 and RdW=0 immediately; opcode 1111111 gives IllegalD=1 with all controls 0.
